// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Owns the PC and assembles each 32-bit instruction from four byte reads on
// the shared byte-wide memory port (little-endian, byte 0 at pc). The
// assembled {pc, inst} is presented to the IF/ID register until the decoder
// accepts it (stall_i low). A redirect from EX (branch_i) overrides
// everything except reset and discards any byte still in flight.
//
// Optional feature: define IF_ICACHE_EN to add a direct-mapped instruction
// cache of ICACHE_LINES entries. A hit skips the memory port entirely.
//
// Parameters:
//   RESET_PC      PC loaded on reset
//   ICACHE_LINES  cache entries (power of 2), only used with IF_ICACHE_EN
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   stall_i           downstream cannot accept the presented instruction
//   branch_i          one-cycle redirect request
//   branch_target_i   redirect PC, bits [1:0] ignored
//   mem_req_o         byte read request
//   mem_addr_o        byte address of the request
//   mem_gnt_i         request accepted this cycle
//   mem_data_i        read byte, valid the cycle after its grant
//   if_valid_o        if_pc_o/if_inst_o hold a valid instruction
//   if_pc_o           PC of the presented instruction
//   if_inst_o         presented instruction
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [2:0]  req_cnt;    // bytes granted for the current instruction (0..4)
    logic [1:0]  rsp_cnt;    // bytes captured so far (0..3)
    logic        rsp_pend;   // a granted byte arrives on mem_data_i this cycle
    logic [23:0] byte_buf;   // bytes 0..2 while waiting for byte 3
    logic        mem_fire;
    logic        last_byte;
    logic        cache_hit;

    assign mem_fire  = mem_req_o & mem_gnt_i;
    // Final byte lands this cycle; a simultaneous redirect drops it.
    assign last_byte = (state == FETCH) && rsp_pend && (rsp_cnt == 2'd3) && !branch_i;

`ifdef IF_ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] c_valid;
    logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
    logic [31:0]             c_inst [ICACHE_LINES];
    logic [IDX_W-1:0]        c_idx;
    logic [TAG_W-1:0]        c_tag_pc;

    assign c_idx    = pc[2 +: IDX_W];
    assign c_tag_pc = pc[31 -: TAG_W];

    // Lookup only at the start of an instruction, before any byte is requested.
    assign cache_hit = (state == FETCH) && (req_cnt == 3'd0) && (rsp_cnt == 2'd0) &&
                       !rsp_pend && c_valid[c_idx] && (c_tag[c_idx] == c_tag_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= '0;
        end else if (last_byte) begin
            c_valid[c_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (last_byte) begin
            c_tag[c_idx]  <= c_tag_pc;
            c_inst[c_idx] <= {mem_data_i, byte_buf};
        end
    end
`else
    // No cache storage; the comparison is constant false and keeps
    // ICACHE_LINES referenced in this build.
    assign cache_hit = (ICACHE_LINES < 0);
`endif

    always_comb begin
        state_nxt  = state;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        if (branch_i) begin
            state_nxt = FETCH;
        end else if (state == FETCH) begin
            if (cache_hit || last_byte) begin
                state_nxt = HOLD;
            end else if (req_cnt < 3'd4) begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc + {29'd0, req_cnt};
            end
        end else if (!stall_i) begin
            state_nxt = FETCH;
        end
        if (rst) begin
            mem_req_o  = 1'b0;
            mem_addr_o = '0;
        end
    end

    // Fetch control and presented instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_cnt    <= 3'd0;
            rsp_cnt    <= 2'd0;
            rsp_pend   <= 1'b0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_inst_o  <= NOP;
        end else begin
            state    <= state_nxt;
            // No request is issued in a redirect cycle, so nothing granted
            // before the redirect can be mistaken for a new byte afterwards.
            rsp_pend <= mem_fire;
            if (branch_i) begin
                pc         <= branch_target_i & ~32'd3;
                req_cnt    <= 3'd0;
                rsp_cnt    <= 2'd0;
                if_valid_o <= 1'b0;
            end else if (state == FETCH) begin
                if (mem_fire) begin
                    req_cnt <= req_cnt + 3'd1;
                end
                if (rsp_pend) begin
                    rsp_cnt <= rsp_cnt + 2'd1;
                end
                if (last_byte) begin
                    if_valid_o <= 1'b1;
                    if_pc_o    <= pc;
                    if_inst_o  <= {mem_data_i, byte_buf};
                end
`ifdef IF_ICACHE_EN
                if (cache_hit) begin
                    if_valid_o <= 1'b1;
                    if_pc_o    <= pc;
                    if_inst_o  <= c_inst[c_idx];
                end
`endif
            end else if (!stall_i) begin
                pc         <= pc + 32'd4;
                req_cnt    <= 3'd0;
                rsp_cnt    <= 2'd0;
                if_valid_o <= 1'b0;
            end
        end
    end

    // Byte assembly for bytes 0..2; byte 3 goes straight to the output word
    always_ff @(posedge clk) begin
        if (rsp_pend && !branch_i) begin
            case (rsp_cnt)
                2'd0:    byte_buf[7:0]   <= mem_data_i;
                2'd1:    byte_buf[15:8]  <= mem_data_i;
                2'd2:    byte_buf[23:16] <= mem_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed self-checking bench for if_fetch.
//
// Memory model: bytes 0..3 hold 13,05,10,00 (addi a0,x0,1); every other
// address a returns a[7:0] + a[15:8] + 8'h30. Expected words below are worked
// out by hand from that rule, e.g. pc 0x004 -> 32'h37363534,
// pc 0x104 -> 32'h38373635, pc 0xFFFF_FFFC -> 32'h2E2D2C2B,
// pc 0x040 -> 32'h73727170, pc 0x044 -> 32'h77767574.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_data_i = 8'h00;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_data_i      (mem_data_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] + a[15:8] + 8'h30;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i) mem_data_i <= mem_byte(mem_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (if_valid_o) break;
            step();
        end
        check({tag, "_valid_seen"}, {31'd0, if_valid_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = 32'd0;
        mem_gnt_i       = 1'b1;
        step();
        step();
        check("rst_valid", {31'd0, if_valid_o}, 32'd0);
        check("rst_inst",  if_inst_o, 32'h0000_0013);
        check("rst_pc",    if_pc_o, 32'd0);
        check("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check("rst_addr",  mem_addr_o, 32'd0);

        // First fetch, continuous grant: requests in cycles 0..3, valid in 5
        rst = 1'b0;
        #1;
        check("f0_req",  {31'd0, mem_req_o}, 32'd1);
        check("f0_addr", mem_addr_o, 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check("f0_req",  {31'd0, mem_req_o}, 32'd1);
            check("f0_addr", mem_addr_o, i);
        end
        step();
        check("f0_c4_req",   {31'd0, mem_req_o}, 32'd0);
        check("f0_c4_valid", {31'd0, if_valid_o}, 32'd0);
        step();
        check("f0_c5_valid", {31'd0, if_valid_o}, 32'd1);
        check("f0_inst",     if_inst_o, 32'h0010_0513);
        check("f0_pc",       if_pc_o, 32'd0);

        // Stall for 3 cycles while valid
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", {31'd0, if_valid_o}, 32'd1);
            check("hold_pc",    if_pc_o, 32'd0);
            check("hold_inst",  if_inst_o, 32'h0010_0513);
            check("hold_req",   {31'd0, mem_req_o}, 32'd0);
            if (i == 2) stall_i = 1'b0;
        end
        step();
        check("rel_req",  {31'd0, mem_req_o}, 32'd1);
        check("rel_addr", mem_addr_o, 32'd4);

        // Grant withheld for 2 cycles on byte 2
        step();
        check("g_addr5", mem_addr_o, 32'd5);
        step();
        mem_gnt_i = 1'b0;
        #1;
        check("g_wait_req",  {31'd0, mem_req_o}, 32'd1);
        check("g_wait_addr", mem_addr_o, 32'd6);
        step();
        check("g_wait_req",  {31'd0, mem_req_o}, 32'd1);
        check("g_wait_addr", mem_addr_o, 32'd6);
        mem_gnt_i = 1'b1;
        wait_valid("gnt", 10);
        check("g_inst", if_inst_o, 32'h3736_3534);
        check("g_pc",   if_pc_o, 32'd4);

        // Redirect after byte 1 is granted
        step();
        check("br_addr8", mem_addr_o, 32'd8);
        step();
        check("br_addr9", mem_addr_o, 32'd9);
        step();
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_0106;
        #1;
        check("br_req_taken", {31'd0, mem_req_o}, 32'd0);
        step();
        branch_i = 1'b0;
        #1;
        check("br_new_req",  {31'd0, mem_req_o}, 32'd1);
        check("br_new_addr", mem_addr_o, 32'h0000_0104);
        wait_valid("br", 10);
        check("br_pc",   if_pc_o, 32'h0000_0104);
        check("br_inst", if_inst_o, 32'h3837_3635);

        // Redirect coinciding with final byte capture
        step();
        check("bc_addr", mem_addr_o, 32'h0000_0108);
        repeat (4) step();
        check("bc_c4_req",   {31'd0, mem_req_o}, 32'd0);
        check("bc_c4_valid", {31'd0, if_valid_o}, 32'd0);
        branch_i        = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        #1;
        step();
        branch_i = 1'b0;
        #1;
        check("bc_dropped", {31'd0, if_valid_o}, 32'd0);
        check("bc_req",     {31'd0, mem_req_o}, 32'd1);
        check("bc_addr",    mem_addr_o, 32'hFFFF_FFFC);
        wait_valid("wrap", 10);
        check("wrap_pc",   if_pc_o, 32'hFFFF_FFFC);
        check("wrap_inst", if_inst_o, 32'h2E2D_2C2B);
        step();
`ifdef IF_ICACHE_EN
        check("wrap_hit_req", {31'd0, mem_req_o}, 32'd0);
`else
        check("wrap_req",  {31'd0, mem_req_o}, 32'd1);
        check("wrap_addr", mem_addr_o, 32'd0);
`endif

        // Reset in the middle of a fetch
        rst = 1'b1;
        step();
        check("rst2_valid", {31'd0, if_valid_o}, 32'd0);
        check("rst2_inst",  if_inst_o, 32'h0000_0013);
        check("rst2_pc",    if_pc_o, 32'd0);
        check("rst2_req",   {31'd0, mem_req_o}, 32'd0);

`ifdef IF_ICACHE_EN
        // Two-instruction loop at 0x40 run twice; second pass all hits
        rst             = 1'b0;
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_0040;
        #1;
        step();
        branch_i = 1'b0;
        #1;
        check("c_miss_addr", mem_addr_o, 32'h0000_0040);
        wait_valid("c_miss0", 10);
        check("c_miss0_inst", if_inst_o, 32'h7372_7170);
        step();
        wait_valid("c_miss1", 10);
        check("c_miss1_inst", if_inst_o, 32'h7776_7574);
        check("c_miss1_pc",   if_pc_o, 32'h0000_0044);
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_0040;
        #1;
        step();
        branch_i = 1'b0;
        #1;
        check("c_hit0_req", {31'd0, mem_req_o}, 32'd0);
        step();
        check("c_hit0_valid", {31'd0, if_valid_o}, 32'd1);
        check("c_hit0_inst",  if_inst_o, 32'h7372_7170);
        step();
        check("c_hit1_req", {31'd0, mem_req_o}, 32'd0);
        step();
        check("c_hit1_valid", {31'd0, if_valid_o}, 32'd1);
        check("c_hit1_inst",  if_inst_o, 32'h7776_7574);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
